// File: rtl/button_pkg.sv
// Shared constants and helpers for the button pulse generator.
// Defaults are tuned for the board clock; the bench overrides them.
package button_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 1000;
  localparam int DEF_REPEAT_CYCLES   = 250;

  // Per-channel event bundle handed from a channel slice to the top.
  typedef struct packed {
    logic level;
    logic pulse_rise;
    logic pulse_fall;
    logic hold_pulse;
    logic hold_level;
    logic repeat_pulse;
  } btn_evt_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Button bank bus: raw levels in, debounced level and event pulses out.
// master = button source / consumer side, slave = pulse generator.
interface button_pulse_gen_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pulse_rise;
  logic [N_CH-1:0] pulse_fall;
  logic [N_CH-1:0] hold_pulse;
  logic [N_CH-1:0] hold_level;
  logic [N_CH-1:0] repeat_pulse;

  modport master (
    output btn,
    input  level, pulse_rise, pulse_fall, hold_pulse, hold_level, repeat_pulse
  );

  modport slave (
    input  btn,
    output level, pulse_rise, pulse_fall, hold_pulse, hold_level, repeat_pulse
  );
endinterface

// File: rtl/button_channel.sv
// One button slice: synchroniser, debounce, edge pulses, long-press hold and
// auto-repeat (auto-repeat only when BUTTON_PULSE_GEN_AUTO_REPEAT_EN is defined).
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic     sp_clk,
  input  logic     rst_n,
  input  logic     btn,
  output btn_evt_t evt
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int HD_W = cnt_w(HOLD_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_MAX  = HD_W'(HOLD_CYCLES);

  if (SYNC_STAGES < 2)     begin : g_bad_sync $error("SYNC_STAGES must be >= 2");     end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db   $error("DEBOUNCE_CYCLES must be >= 1"); end
  if (HOLD_CYCLES < 2)     begin : g_bad_hold $error("HOLD_CYCLES must be >= 2");     end
  if (REPEAT_CYCLES < 1)   begin : g_bad_rpt  $error("REPEAT_CYCLES must be >= 1");   end

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        db_cnt;
  logic [HD_W-1:0]        hd_cnt;
  logic level_q, rise_q, fall_q, hold_pulse_q, hold_level_q, rpt;
  logic s, flip, level_nx, hold_hit;

  assign s        = sync[SYNC_STAGES-1];
  assign flip     = (s != level_q) && (db_cnt == DB_LAST);
  assign level_nx = flip ? s : level_q;
  // Edge and hold outputs are keyed off the next level so they line up with it.
  assign hold_hit = level_nx && (hd_cnt == HD_LAST);

  always_ff @(posedge sp_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync         <= '0;
      db_cnt       <= '0;
      hd_cnt       <= '0;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      hold_pulse_q <= 1'b0;
      hold_level_q <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      if (s == level_q || flip) db_cnt <= '0;
      else                      db_cnt <= db_cnt + 1'b1;
      level_q <= level_nx;
      rise_q  <= flip && s;
      fall_q  <= flip && !s;
      if (!level_nx)            hd_cnt <= '0;
      else if (hd_cnt != HD_MAX) hd_cnt <= hd_cnt + 1'b1;
      hold_pulse_q <= hold_hit;
      hold_level_q <= level_nx && (hold_level_q || hold_hit);
    end
  end

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
  localparam int RP_W = cnt_w(REPEAT_CYCLES);
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES);

  logic [RP_W-1:0] rp_cnt;
  logic            rp_q;

  // Count starts at 1 in the hold_pulse cycle, so a wrap lands exactly
  // REPEAT_CYCLES after it and every REPEAT_CYCLES thereafter.
  always_ff @(posedge sp_clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_cnt <= '0;
      rp_q   <= 1'b0;
    end else if (!level_nx) begin
      rp_cnt <= '0;
      rp_q   <= 1'b0;
    end else if (hold_hit) begin
      rp_cnt <= RP_W'(1);
      rp_q   <= 1'b0;
    end else if (hold_level_q) begin
      if (rp_cnt == RP_MAX) begin
        rp_cnt <= RP_W'(1);
        rp_q   <= 1'b1;
      end else begin
        rp_cnt <= rp_cnt + 1'b1;
        rp_q   <= 1'b0;
      end
    end else begin
      rp_q <= 1'b0;
    end
  end

  assign rpt = rp_q;
`else
  assign rpt = 1'b0;
`endif

  assign evt = '{level:        level_q,
                 pulse_rise:   rise_q,
                 pulse_fall:   fall_q,
                 hold_pulse:   hold_pulse_q,
                 hold_level:   hold_level_q,
                 repeat_pulse: rpt};

endmodule

// File: rtl/button_pulse_gen.sv
// Multi-channel button pulse generator: N_CH independent button_channel slices.
// Auto-repeat is compiled in with BUTTON_PULSE_GEN_AUTO_REPEAT_EN.
module button_pulse_gen
  import button_pkg::*;
#(
  parameter int N_CH            = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic              sp_clk,
  input  logic              rst_n,
  button_pulse_gen_if.slave bus
);

  btn_evt_t [N_CH-1:0] evt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .sp_clk(sp_clk),
      .rst_n (rst_n),
      .btn   (bus.btn[i]),
      .evt   (evt[i])
    );
  end

  always_comb begin
    bus.level        = '0;
    bus.pulse_rise   = '0;
    bus.pulse_fall   = '0;
    bus.hold_pulse   = '0;
    bus.hold_level   = '0;
    bus.repeat_pulse = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.level[i]        = evt[i].level;
      bus.pulse_rise[i]   = evt[i].pulse_rise;
      bus.pulse_fall[i]   = evt[i].pulse_fall;
      bus.hold_pulse[i]   = evt[i].hold_pulse;
      bus.hold_level[i]   = evt[i].hold_level;
      bus.repeat_pulse[i] = evt[i].repeat_pulse;
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen: N_CH=2, SYNC=2, DEBOUNCE=4, HOLD=20, REPEAT=8.
// Checks repeat pulses when BUTTON_PULSE_GEN_AUTO_REPEAT_EN is defined, else expects 0.
module tb_button_pulse_gen;
  localparam int N_CH = 2;

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic sp_clk = 1'b0;
  logic rst_n  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  button_pulse_gen_if #(.N_CH(N_CH)) bif ();

  button_pulse_gen #(
    .N_CH(N_CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .sp_clk(sp_clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 sp_clk = ~sp_clk;

  // Packed view: {repeat, hold_level, hold_pulse, fall, rise, level}, 2 bits each.
  function automatic logic [11:0] pk(input logic [1:0] lv, ri, fa, hp, hl, rp);
    return {rp, hl, hp, fa, ri, lv};
  endfunction

  task automatic chk(input string tag, input int c, input logic [11:0] exp);
    logic [11:0] o;
    o = pk(bif.level, bif.pulse_rise, bif.pulse_fall,
           bif.hold_pulse, bif.hold_level, bif.repeat_pulse);
    total++;
    assert (o === exp) else begin
      bad++;
      $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, o, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sp_clk);
    #1;
  endtask

  initial begin
    logic lv, rp;
    int   n;
    bif.btn = '0;

    // Reset state
    step(2);
    chk("reset", 0, 12'h000);
    rst_n = 1'b1;
    step(2);
    chk("idle", 0, 12'h000);

    // Clean press on ch0, long hold, auto-repeat; level-high cycle n = c-5
    bif.btn = 2'b01;
    for (int c = 1; c <= 50; c++) begin
      step(1);
      n  = c - 5;
      lv = (c >= 6);
      rp = RPT && (n == 28 || n == 36 || n == 44);
      chk("press", c, pk({1'b0, lv}, {1'b0, c == 6}, 2'b00,
                         {1'b0, n == 20}, {1'b0, n >= 20}, {1'b0, rp}));
    end
    bif.btn = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      chk("long_release", c, pk({1'b0, c < 6}, 2'b00, {1'b0, c == 6},
                                2'b00, {1'b0, c < 6}, 2'b00));
    end

    // Bounce: 1,0,1,0 then steady high
    for (int i = 0; i < 4; i++) begin
      bif.btn = {1'b0, ~i[0]};
      step(1);
      chk("bounce", i, 12'h000);
    end
    bif.btn = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      chk("settle", c, pk({1'b0, c >= 6}, {1'b0, c == 6}, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    bif.btn = 2'b00;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      chk("settle_rel", c, pk({1'b0, c < 6}, 2'b00, {1'b0, c == 6}, 2'b00, 2'b00, 2'b00));
    end

    // Short press: released well before HOLD, no hold pulse
    bif.btn = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      step(1);
      chk("short", c, pk({1'b0, c >= 6}, {1'b0, c == 6}, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    bif.btn = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      chk("short_rel", c, pk({1'b0, c < 6}, 2'b00, {1'b0, c == 6}, 2'b00, 2'b00, 2'b00));
    end

    // Simultaneous press, staggered release (ch0 first, ch1 two cycles later)
    bif.btn = 2'b11;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      chk("both", c, pk({2{c >= 6}}, {2{c == 6}}, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    bif.btn = 2'b10;
    for (int c = 1; c <= 9; c++) begin
      step(1);
      chk("stagger", c, pk({c < 8, c < 6}, 2'b00, {c == 8, c == 6}, 2'b00, 2'b00, 2'b00));
      if (c == 2) bif.btn = 2'b00;
    end

    // Reset mid-press while hold_level is set
    bif.btn = 2'b01;
    step(30);
    chk("pre_reset", 30, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, 12'h000);
    step(3);
    chk("rst_held", 3, 12'h000);
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      chk("post_reset", c, pk({1'b0, c >= 6}, {1'b0, c == 6}, 2'b00, 2'b00, 2'b00, 2'b00));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
